interpolate: RTL and testbench

Linear-interpolating upsampler, the inverse of the 128:1 averaging decimator in the acoustics capture path. Accepts a low-rate stream of 14-bit unsigned samples (one-cycle `I_rdy` strobes, nominally one per 128 clocks) and emits one 14-bit sample per clock that ramps linearly between successive inputs. Sits on the playback/test side of the FPGA, e.g. regenerating full-rate waveforms from decimated data or driving a DAC from a slow sample source.

---
 rtl/interpolate_pkg.sv | 17 +
 rtl/interpolate.sv | 157 +++++++++++++++
 tb/tb_interpolate.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/interpolate_pkg.sv
// interpolate_pkg
//   Shared constants for the acoustics rate-conversion blocks.
//   DW_DEFAULT          sample width shared with the 128:1 decimator
//   LOG2_RATIO_DEFAULT  log2 of the rate-change ratio
//   state_t             interpolator control states
package interpolate_pkg;

  localparam int DW_DEFAULT         = 14;
  localparam int LOG2_RATIO_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no sample seen since reset
    ST_HOLD  = 2'd1,  // output parked on the last target
    ST_RUN   = 2'd2   // ramping toward cur
  } state_t;

endpackage

// File: rtl/interpolate.sv
// interpolate
//   Linear-interpolating upsampler. Each low-rate input sample becomes the
//   end point of a 2^LOG2_RATIO-cycle linear ramp from the previous sample.
//   A one-deep buffer absorbs a sample that arrives before the current ramp
//   finishes.
// Ports
//   I_clk   sole clock
//   I_rst   synchronous active-high reset
//   I_rdy   one-cycle strobe, I_din valid
//   I_din   unsigned input sample
//   O_vld   high once the first sample has reached O_dout, until reset
//   O_dout  interpolated sample, one per clock
//   O_ovf   pulse: the buffered sample was overwritten
//   O_unf   pulse: a ramp ended with no next sample available
module interpolate
  import interpolate_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int LOG2_RATIO = LOG2_RATIO_DEFAULT
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic          I_rdy,
  input  logic [DW-1:0] I_din,
  output logic          O_vld,
  output logic [DW-1:0] O_dout,
  output logic          O_ovf,
  output logic          O_unf
);

  localparam int AW = DW + LOG2_RATIO;
  localparam logic [LOG2_RATIO-1:0] PHASE_LAST = '1;

  state_t                state_reg, state_next;
  logic [DW-1:0]         cur_reg, cur_next;
  logic [AW-1:0]         acc_reg, acc_next;
  logic [DW:0]           delta_reg, delta_next;
  logic [LOG2_RATIO-1:0] phase_reg, phase_next;
  logic [DW-1:0]         pend_reg, pend_next;
  logic                  pend_vld_reg, pend_vld_next;
  logic                  ovf_next, unf_next;
  logic                  load_en;
  logic [DW-1:0]         load_src;
  logic [AW-1:0]         delta_ext;

  logic [DW-1:0]         dout_reg;
  logic                  vld_reg, ovf_reg, unf_reg;

  // acc is unsigned but always lies between two DW-bit end points, so a
  // modular add of the sign-extended step is exact.
  assign delta_ext = {{(AW-DW-1){delta_reg[DW]}}, delta_reg};

  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    acc_next      = acc_reg;
    delta_next    = delta_reg;
    phase_next    = phase_reg;
    pend_next     = pend_reg;
    pend_vld_next = pend_vld_reg;
    ovf_next      = 1'b0;
    unf_next      = 1'b0;
    load_en       = 1'b0;
    load_src      = I_din;

    case (state_reg)
      ST_EMPTY: begin
        // First sample is taken as-is; no ramp up from zero.
        if (I_rdy) begin
          cur_next   = I_din;
          acc_next   = {I_din, {LOG2_RATIO{1'b0}}};
          delta_next = '0;
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (pend_vld_reg) begin
          load_en       = 1'b1;
          load_src      = pend_reg;
          pend_vld_next = I_rdy;
          if (I_rdy) pend_next = I_din;
        end else if (I_rdy) begin
          load_en = 1'b1;
        end
      end

      ST_RUN: begin
        acc_next   = acc_reg + delta_ext;
        phase_next = phase_reg + LOG2_RATIO'(1);
        if (phase_reg == PHASE_LAST) begin
          // Last add of the segment lands exactly on cur; chain straight
          // into the next segment when a sample is available.
          if (pend_vld_reg) begin
            load_en       = 1'b1;
            load_src      = pend_reg;
            pend_vld_next = I_rdy;
            if (I_rdy) pend_next = I_din;
          end else if (I_rdy) begin
            load_en = 1'b1;
          end else begin
            unf_next   = 1'b1;
            state_next = ST_HOLD;
          end
        end else if (I_rdy) begin
          pend_next     = I_din;
          pend_vld_next = 1'b1;
          ovf_next      = pend_vld_reg;
        end
      end

      default: state_next = ST_EMPTY;
    endcase

    // Segment load: new target and step; acc continues from where it is.
    if (load_en) begin
      delta_next = {1'b0, load_src} - {1'b0, cur_reg};
      cur_next   = load_src;
      phase_next = '0;
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_reg    <= ST_EMPTY;
      cur_reg      <= '0;
      acc_reg      <= '0;
      delta_reg    <= '0;
      phase_reg    <= '0;
      pend_reg     <= '0;
      pend_vld_reg <= 1'b0;
      dout_reg     <= '0;
      vld_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      acc_reg      <= acc_next;
      delta_reg    <= delta_next;
      phase_reg    <= phase_next;
      pend_reg     <= pend_next;
      pend_vld_reg <= pend_vld_next;
      dout_reg     <= acc_reg[AW-1:LOG2_RATIO];
      vld_reg      <= (state_reg != ST_EMPTY);
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
    end
  end

  assign O_dout = dout_reg;
  assign O_vld  = vld_reg;
  assign O_ovf  = ovf_reg;
  assign O_unf  = unf_reg;

endmodule

// File: tb/tb_interpolate.sv
// tb_interpolate
//   Self-checking bench for interpolate. Each test task pushes the expected
//   per-cycle output words into a scoreboard queue as it starts driving,
//   then pops and compares one word per clock on the falling edge.
module tb_interpolate;

  logic        I_clk;
  logic        I_rst;
  logic        I_rdy;
  logic [13:0] I_din;
  logic        O_vld;
  logic [13:0] O_dout;
  logic        O_ovf;
  logic        O_unf;

  typedef struct packed {
    logic [13:0] dout;
    logic        vld;
    logic        ovf;
    logic        unf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  interpolate dut (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_rdy (I_rdy),
    .I_din (I_din),
    .O_vld (O_vld),
    .O_dout(O_dout),
    .O_ovf (O_ovf),
    .O_unf (O_unf)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Ideal truncated linear interpolation from a to b after j of 128 steps.
  function automatic int lerp(input int a, input int b, input int j);
    int jj;
    jj = j;
    if (jj < 0) jj = 0;
    if (jj > 128) jj = 128;
    return (a * 128 + (b - a) * jj) / 128;
  endfunction

  function automatic obs_t mk(input int d, input logic v, input logic o, input logic u);
    obs_t e;
    e.dout = 14'(d);
    e.vld  = v;
    e.ovf  = o;
    e.unf  = u;
    return e;
  endfunction

  task automatic send(input int v);
    I_rdy = 1'b1;
    I_din = 14'(v);
    $display("[%0t] drive sample %0d", $time, v);
  endtask

  task automatic idle();
    I_rdy = 1'b0;
    I_din = '0;
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    idle();
    @(negedge I_clk);
    I_rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, got;
    I_rst = 1'b1;
    idle();
    for (int k = 1; k <= 5; k++) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge I_clk);
      e   = exp_q.pop_front();
      got = {O_dout, O_vld, O_ovf, O_unf};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset k=%0d got dout=%0d vld=%b ovf=%b unf=%b want dout=%0d vld=%b ovf=%b unf=%b",
                 k, got.dout, got.vld, got.ovf, got.unf, e.dout, e.vld, e.ovf, e.unf);
      end
      if (k == 3) I_rst = 1'b0;
    end
  endtask

  task automatic test_first_sample(input int v);
    obs_t e, got;
    send(v);
    exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    for (int k = 2; k <= 10; k++) exp_q.push_back(mk(v, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      @(negedge I_clk);
      e   = exp_q.pop_front();
      got = {O_dout, O_vld, O_ovf, O_unf};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL first_sample(%0d) k=%0d got dout=%0d vld=%b ovf=%b unf=%b want dout=%0d vld=%b ovf=%b unf=%b",
                 v, k, got.dout, got.vld, got.ovf, got.unf, e.dout, e.vld, e.ovf, e.unf);
      end
      idle();
    end
  endtask

  // Entered in HOLD at value a; loads b and follows the whole segment.
  task automatic test_ramp(input int a, input int b);
    obs_t e, got;
    send(b);
    for (int k = 1; k <= 132; k++)
      exp_q.push_back(mk(lerp(a, b, k - 2), 1'b1, 1'b0, k == 129));
    for (int k = 1; k <= 132; k++) begin
      @(negedge I_clk);
      e   = exp_q.pop_front();
      got = {O_dout, O_vld, O_ovf, O_unf};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ramp(%0d->%0d) k=%0d got dout=%0d vld=%b ovf=%b unf=%b want dout=%0d vld=%b ovf=%b unf=%b",
                 a, b, k, got.dout, got.vld, got.ovf, got.unf, e.dout, e.vld, e.ovf, e.unf);
      end
      idle();
    end
  endtask

  // Entered in HOLD at 5000; a 5000 sample every 128 clocks, then stop.
  task automatic test_continuous();
    obs_t e, got;
    send(5000);
    for (int k = 1; k <= 514; k++)
      exp_q.push_back(mk(5000, 1'b1, 1'b0, k == 513));
    for (int k = 1; k <= 514; k++) begin
      @(negedge I_clk);
      e   = exp_q.pop_front();
      got = {O_dout, O_vld, O_ovf, O_unf};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL continuous k=%0d got dout=%0d vld=%b ovf=%b unf=%b want dout=%0d vld=%b ovf=%b unf=%b",
                 k, got.dout, got.vld, got.ovf, got.unf, e.dout, e.vld, e.ovf, e.unf);
      end
      if (k % 128 == 0 && k <= 384) send(5000);
      else idle();
    end
  endtask

  // Entered in HOLD at 5000; 300 loads, 400 buffered, 500 overwrites it.
  task automatic test_overflow();
    obs_t e, got;
    int   d;
    send(300);
    for (int k = 1; k <= 260; k++) begin
      d = (k <= 130) ? lerp(5000, 300, k - 2) : lerp(300, 500, k - 130);
      exp_q.push_back(mk(d, 1'b1, k == 21, k == 257));
    end
    for (int k = 1; k <= 260; k++) begin
      @(negedge I_clk);
      e   = exp_q.pop_front();
      got = {O_dout, O_vld, O_ovf, O_unf};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL overflow k=%0d got dout=%0d vld=%b ovf=%b unf=%b want dout=%0d vld=%b ovf=%b unf=%b",
                 k, got.dout, got.vld, got.ovf, got.unf, e.dout, e.vld, e.ovf, e.unf);
      end
      if (k == 10) send(400);
      else if (k == 20) send(500);
      else idle();
    end
  endtask

  // Entered in HOLD at 500; reset mid-ramp, then a fresh first sample.
  task automatic test_reset_mid();
    obs_t e, got;
    send(1000);
    for (int k = 1; k <= 60; k++) begin
      if (k <= 50)      exp_q.push_back(mk(lerp(500, 1000, k - 2), 1'b1, 1'b0, 1'b0));
      else if (k <= 54) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
      else              exp_q.push_back(mk(777, 1'b1, 1'b0, 1'b0));
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge I_clk);
      e   = exp_q.pop_front();
      got = {O_dout, O_vld, O_ovf, O_unf};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d got dout=%0d vld=%b ovf=%b unf=%b want dout=%0d vld=%b ovf=%b unf=%b",
                 k, got.dout, got.vld, got.ovf, got.unf, e.dout, e.vld, e.ovf, e.unf);
      end
      idle();
      I_rst = (k == 50);
      if (k == 53) send(777);
    end
  endtask

  initial begin
    I_rst = 1'b1;
    I_rdy = 1'b0;
    I_din = '0;
    @(negedge I_clk);
    test_reset();
    test_first_sample(100);
    test_ramp(100, 228);
    do_reset();
    test_first_sample(16383);
    test_ramp(16383, 0);
    do_reset();
    test_first_sample(5000);
    test_continuous();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
